// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch button front end: clock rate, default
// button timings and a millisecond-to-cycle helper.
package stopwatch_pkg;
  localparam int CLK_HZ = 100_000_000;

  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int DEBOUNCE_CYCLES_DEF  = ms_to_cycles(10);
  localparam int LONGPRESS_CYCLES_DEF = ms_to_cycles(1000);
  localparam int CNT_W_DEF            = 27;
endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchroniser, saturating debounce counter,
// accepted (stable) level, its one-cycle-delayed copy and a registered press pulse.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic i_raw,
  output logic o_stable_q,
  output logic o_press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_q;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // The new level is accepted only after it differed from the stable level
  // for DEBOUNCE_CYCLES consecutive cycles; any return to stable restarts it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (r_sync2 == r_stable) begin
      r_stable <= r_stable;
      r_cnt    <= '0;
    end else if (r_cnt >= CNT_MAX) begin
      r_stable <= r_sync2;
      r_cnt    <= '0;
    end else begin
      r_stable <= r_stable;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stable_q <= 1'b0;
      r_press    <= 1'b0;
    end else begin
      r_stable_q <= r_stable;
      r_press    <= r_stable & ~r_stable_q;
    end
  end

  assign o_stable_q = r_stable_q;
  assign o_press    = r_press;

endmodule

// File: rtl/stopwatch_buttons.sv
// Stopwatch button conditioner: run toggle on start presses, one-cycle clear
// with priority over start. Optional long-press clear under STOPWATCH_LONGPRESS_EN.
module stopwatch_buttons
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEF,
  parameter int LONGPRESS_CYCLES = LONGPRESS_CYCLES_DEF,
  parameter int CNT_W            = CNT_W_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_start_raw,
  input  logic btn_clear_raw,
  output logic run,
  output logic clear,
  output logic start_db,
  output logic clear_db
);

  if (DEBOUNCE_CYCLES < 2 || LONGPRESS_CYCLES < 2 ||
      $clog2(DEBOUNCE_CYCLES) > CNT_W || $clog2(LONGPRESS_CYCLES + 1) > CNT_W) begin : g_bad_params
    $error("stopwatch_buttons: timing parameters out of range for CNT_W");
  end

  logic w_start_stable_q;
  logic w_start_press;
  logic w_clear_stable_q;
  logic w_clear_press;
  logic w_long;
  logic w_clear_evt;
  logic w_run_next;

  logic r_run;
  logic r_clear;
  logic r_start_db;
  logic r_clear_db;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_start_db (
    .clock      (clock),
    .reset      (reset),
    .i_raw      (btn_start_raw),
    .o_stable_q (w_start_stable_q),
    .o_press    (w_start_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_clear_db (
    .clock      (clock),
    .reset      (reset),
    .i_raw      (btn_clear_raw),
    .o_stable_q (w_clear_stable_q),
    .o_press    (w_clear_press)
  );

`ifdef STOPWATCH_LONGPRESS_EN
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LONGPRESS_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_TRIG = CNT_W'(LONGPRESS_CYCLES - 2);

  logic [CNT_W-1:0] r_hold;

  // Hold time of the debounced start level; saturates so the clear fires once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hold <= '0;
    end else if (!r_start_db) begin
      r_hold <= '0;
    end else if (r_hold != HOLD_MAX) begin
      r_hold <= r_hold + 1'b1;
    end else begin
      r_hold <= r_hold;
    end
  end

  assign w_long = r_start_db && (r_hold == HOLD_TRIG);
`else
  assign w_long = 1'b0;
`endif

  // Clear (button or long press) overrides a coincident start toggle.
  always_comb begin
    w_clear_evt = w_clear_press | w_long;
    if (w_clear_evt) begin
      w_run_next = 1'b0;
    end else if (w_start_press) begin
      w_run_next = ~r_run;
    end else begin
      w_run_next = r_run;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_run      <= 1'b0;
      r_clear    <= 1'b0;
      r_start_db <= 1'b0;
      r_clear_db <= 1'b0;
    end else begin
      r_run      <= w_run_next;
      r_clear    <= w_clear_evt;
      r_start_db <= w_start_stable_q;
      r_clear_db <= w_clear_stable_q;
    end
  end

  assign run      = r_run;
  assign clear    = r_clear;
  assign start_db = r_start_db;
  assign clear_db = r_clear_db;

endmodule

// File: tb/tb_stopwatch_buttons.sv
// Scoreboard bench for stopwatch_buttons: the driver pushes per-cycle expectations
// from a sample-level reference model, a monitor pops and compares after each edge.
module tb_stopwatch_buttons;

  localparam int DB = 8;
  localparam int LP = 64;

  typedef struct packed {
    bit run;
    bit clear;
    bit start_db;
    bit clear_db;
  } exp_t;

  logic clock;
  logic reset;
  logic btn_start_raw;
  logic btn_clear_raw;
  logic run;
  logic clear;
  logic start_db;
  logic clear_db;

  int   n_vec;
  int   n_err;
  bit   rel_req;
  exp_t exp_q[$];

  // Reference model state: per button the accepted level and the length of the
  // current run of samples that disagree with it; m_hist[b][j] is the accepted
  // level after the sample taken j edges ago.
  int m_len[2];
  bit m_acc[2];
  bit m_hist[2][6];
  bit m_run;
  bit m_clear;
  bit m_sdb;
  bit m_cdb;
  int m_hold;

  stopwatch_buttons #(
    .DEBOUNCE_CYCLES  (DB),
    .LONGPRESS_CYCLES (LP),
    .CNT_W            (27)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .btn_start_raw (btn_start_raw),
    .btn_clear_raw (btn_clear_raw),
    .run           (run),
    .clear         (clear),
    .start_db      (start_db),
    .clear_db      (clear_db)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) begin
      m_len[b] = 0;
      m_acc[b] = 1'b0;
      for (int j = 0; j < 6; j++) m_hist[b][j] = 1'b0;
    end
    m_run   = 1'b0;
    m_clear = 1'b0;
    m_sdb   = 1'b0;
    m_cdb   = 1'b0;
    m_hold  = 0;
  endfunction

  // A level is accepted once DB consecutive samples disagree with the accepted
  // level; its effect on the outputs appears 4 edges after the last such sample.
  function automatic void model_edge(input bit s, input bit c, output exp_t e);
    bit raw[2];
    bit press[2];
    bit lng;
    raw[0] = s;
    raw[1] = c;
    for (int b = 0; b < 2; b++) begin
      for (int j = 5; j > 0; j--) m_hist[b][j] = m_hist[b][j-1];
      if (raw[b] == m_acc[b]) begin
        m_len[b] = 0;
      end else begin
        m_len[b]++;
        if (m_len[b] == DB) begin
          m_acc[b] = raw[b];
          m_len[b] = 0;
        end
      end
      m_hist[b][0] = m_acc[b];
      press[b] = m_hist[b][4] & ~m_hist[b][5];
    end
    lng = 1'b0;
`ifdef STOPWATCH_LONGPRESS_EN
    if (m_sdb) begin
      if (m_hold < LP) m_hold++;
      lng = (m_hold == LP - 1);
    end else begin
      m_hold = 0;
    end
`endif
    if (press[1] || lng) begin
      m_clear = 1'b1;
      m_run   = 1'b0;
    end else begin
      m_clear = 1'b0;
      if (press[0]) m_run = ~m_run;
    end
    m_sdb = m_hist[0][4];
    m_cdb = m_hist[1][4];
    e.run      = m_run;
    e.clear    = m_clear;
    e.start_db = m_sdb;
    e.clear_db = m_cdb;
  endfunction

  // One clock of stimulus: drive at the falling edge, push the expectation for the next rising edge.
  task automatic step(input bit s, input bit c);
    exp_t e;
    @(negedge clock);
    if (rel_req) begin
      reset   = 1'b1;
      rel_req = 1'b0;
    end
    btn_start_raw = s;
    btn_clear_raw = c;
    if (!reset) e = '0;
    else model_edge(s, c, e);
    exp_q.push_back(e);
  endtask

  task automatic hold(input bit s, input bit c, input int n);
    for (int i = 0; i < n; i++) step(s, c);
  endtask

  // Reset pulse entirely between two rising edges; outputs must drop without a clock.
  task automatic async_reset_step(input bit s, input bit c);
    exp_t e;
    @(negedge clock);
    #1 reset = 1'b0;
    #1;
    n_vec++;
    if ({run, clear, start_db, clear_db} !== 4'b0000) begin
      n_err++;
      $display("FAIL async_reset @%0t: got run=%b clear=%b start_db=%b clear_db=%b, expected all 0",
               $time, run, clear, start_db, clear_db);
    end
    #1 reset = 1'b1;
    model_reset();
    btn_start_raw = s;
    btn_clear_raw = c;
    model_edge(s, c, e);
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per rising edge, compared 1 time unit after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if ({run, clear, start_db, clear_db} !== {e.run, e.clear, e.start_db, e.clear_db}) begin
          n_err++;
          $display("FAIL outputs @%0t: got run=%b clear=%b start_db=%b clear_db=%b, expected run=%b clear=%b start_db=%b clear_db=%b",
                   $time, run, clear, start_db, clear_db, e.run, e.clear, e.start_db, e.clear_db);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int seg_len[2];
    bit seg_lvl[2];
    bit lvl;
    n_vec         = 0;
    n_err         = 0;
    rel_req       = 1'b0;
    reset         = 1'b0;
    btn_start_raw = 1'b1;
    btn_clear_raw = 1'b1;
    model_reset();

    // Reset held with both buttons pressed; clear drops before the first post-reset sample.
    hold(1'b1, 1'b1, 5);
    rel_req = 1'b1;
    hold(1'b1, 1'b0, 20);
    hold(1'b0, 1'b0, 20);

    // Bounce: 3-cycle toggles are rejected, the final hold is accepted once.
    lvl = 1'b1;
    for (int i = 0; i < 10; i++) begin
      hold(lvl, 1'b0, 3);
      lvl = ~lvl;
    end
    hold(1'b1, 1'b0, 25);
    hold(1'b0, 1'b0, 20);

    // Random short bounce bursts on both buttons, all shorter than DB.
    for (int i = 0; i < 12; i++) begin
      hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, DB - 1));
      hold(1'b0, 1'b0, $urandom_range(1, DB - 1));
    end
    hold(1'b0, 1'b0, 15);

    // Two clean presses 50 cycles apart.
    hold(1'b1, 1'b0, 15);
    hold(1'b0, 1'b0, 35);
    hold(1'b1, 1'b0, 15);
    hold(1'b0, 1'b0, 35);

`ifdef STOPWATCH_LONGPRESS_EN
    // Long press, then release.
    hold(1'b1, 1'b0, 100);
    hold(1'b0, 1'b0, 30);
`endif

    // Simultaneous start and clear presses with run=1.
    hold(1'b1, 1'b0, 15);
    hold(1'b0, 1'b0, 20);
    hold(1'b1, 1'b1, 20);
    hold(1'b0, 1'b0, 20);

    // Asynchronous reset with run=1, then a fresh press.
    hold(1'b1, 1'b0, 15);
    hold(1'b0, 1'b0, 20);
    async_reset_step(1'b0, 1'b0);
    hold(1'b0, 1'b0, 5);
    hold(1'b1, 1'b0, 15);
    hold(1'b0, 1'b0, 20);

    // Reset mid-debounce with start held through reset release.
    hold(1'b1, 1'b0, 4);
    async_reset_step(1'b1, 1'b0);
    hold(1'b1, 1'b0, 20);
    hold(1'b0, 1'b0, 20);

    // Random segments of random level and length on both buttons.
    for (int b = 0; b < 2; b++) begin
      seg_len[b] = 0;
      seg_lvl[b] = 1'b0;
    end
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 2; b++) begin
        if (seg_len[b] == 0) begin
          seg_lvl[b] = 1'($urandom_range(0, 1));
          seg_len[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DB - 1)
                                                    : $urandom_range(DB - 2, 24);
        end
        seg_len[b]--;
      end
      step(seg_lvl[0], seg_lvl[1]);
    end
    hold(1'b0, 1'b0, 20);

    @(negedge clock);
    @(negedge clock);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_buttons.md
Name: stopwatch_buttons

Overview:
Front-end button conditioner that sits directly upstream of the stopwatch core. It takes raw, bouncy, asynchronous push-buttons from the board and does three things: synchronises them, debounces them, and edge-detects them. From that it produces a clean run level that drives the stopwatch start input, plus a one-cycle clear pulse. One instance per stopwatch, in the 100 MHz clock domain.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, cycles an input must be stable before it is accepted (10 ms at 100 MHz); minimum 2.
LONGPRESS_CYCLES, 100_000_000, cycles the debounced start button must stay high to trigger a clear (1 s); used only with the optional feature.
CNT_W, 27, counter width; must hold max(DEBOUNCE_CYCLES, LONGPRESS_CYCLES).

Ports:
clock  in  1  system clock, all state on rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
btn_start_raw  in  1  raw start/stop button, active-high, asynchronous.
btn_clear_raw  in  1  raw clear button, active-high, asynchronous.
run  out  1  level; 1 = stopwatch counting; connects to stopwatch start.
clear  out  1  one-cycle pulse; zeroes the stopwatch count.
start_db  out  1  debounced start button level (for LEDs/debug).
clear_db  out  1  debounced clear button level.

Behaviour:
- Reset (reset=0, async): all sync flops, stable levels, counters, run, clear, start_db and clear_db go to 0. Outputs stay 0 until the first valid debounced edge after release.
- Synchroniser: 2-FF chain per button; nothing else samples the raw input.
- Debounce, per button:
  - cnt clears whenever sync == stable.
  - When sync != stable, cnt increments each cycle.
  - When cnt reaches DEBOUNCE_CYCLES-1, stable <= sync and cnt <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Edge detect: press = stable & ~stable_q, registered.
- Latency: a clean input change produces the press pulse DEBOUNCE_CYCLES+3 cycles after the first clock edge that samples the new level.
- run:
  - Toggles on each start press.
  - Forced to 0 on any clear event.
- clear:
  - Pulses high for exactly one cycle on a clear press.
  - Never held high continuously, even while the button is held.
- Simultaneous start press and clear press in the same cycle: clear wins. clear=1 and run=0 next cycle; the toggle is discarded.
- Release edges have no effect on run or clear.
- Reset mid-debounce: the counter is discarded. An input already held high through reset release is seen as a fresh press after DEBOUNCE_CYCLES+3 cycles.
- Counters saturate; they never wrap.

Optional Feature:
Macro STOPWATCH_LONGPRESS_EN.
- Defined:
  - A hold counter increments while start_db=1 and saturates at LONGPRESS_CYCLES.
  - On the cycle it reaches LONGPRESS_CYCLES-1, clear pulses once and run is forced to 0.
  - The hold counter clears when start_db=0.
  - The release after a long press does not toggle run.
- Undefined: the hold counter and its logic are absent. Holding start has no effect beyond the initial toggle. LONGPRESS_CYCLES is ignored.

Decomposition:
- Package stopwatch_pkg holds:
  - localparam CLK_HZ = 100_000_000;
  - default DEBOUNCE_CYCLES and LONGPRESS_CYCLES;
  - the ms-to-cycles helper function.
- One sub-module, btn_debounce: 2-FF sync, debounce counter, stable level and press pulse. It is instantiated twice, once for start and once for clear. Toggle, clear-priority and long-press logic stay in the top.

Test Plan:
- Testbench settings: DEBOUNCE_CYCLES=8, LONGPRESS_CYCLES=64; test 4 also needs STOPWATCH_LONGPRESS_EN.
1. Reset: hold reset=0 for 5 cycles with both buttons=1 -> run=clear=start_db=clear_db=0 throughout. After release, start_db rises at cycle 11 (8+3) and run=1.
2. Bounce: start toggles 1/0 every 3 cycles for 30 cycles, then holds 1 -> exactly one run 0->1 transition, at 11 cycles after the last toggle.
3. Toggle: two clean start presses 50 cycles apart -> run goes 1 then 0; clear never asserts.
4. Long press: hold start for 100 cycles -> run=1 at cycle 11, then clear=1 for one cycle with run=0 at cycle 11+63. Release -> run stays 0.
5. Simultaneous: with run=1, both buttons rise on the same cycle -> after 11 cycles clear=1 for one cycle and run=0; no toggle back to 1.
6. Async reset mid-count: with run=1, drop reset for 1 cycle between clock edges -> run=0 immediately, without waiting for a clock edge. The next press sets run=1.
